// File: rtl/axi_pkg.sv
// Shared AXI constants, slave FSM state type and debug view for the SRAM slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } slave_state_e;

    typedef struct packed {
        slave_state_e state;
        logic [2:0]   size;
        logic [7:0]   beat;
    } slave_dbg_t;

    // Only FIXED and INCR are served; WRAP and the reserved code error every beat.
    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port word-addressed storage: synchronous read, byte-enable write.
module sram_1rw #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 1024,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // rdata_o keeps its value whenever the port is idle or writing.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (wstrb_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI slave in front of a single-port SRAM; one read or write burst in flight at a time.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [3:0]            arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [7:0]            arlen_i,
    input  logic [2:0]            arsize_i,
    input  logic [1:0]            arburst_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [3:0]            rid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [3:0]            awid_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [7:0]            awlen_i,
    input  logic [2:0]            awsize_i,
    input  logic [1:0]            awburst_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wlast_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [3:0]            bid_o,
    output logic [1:0]            bresp_o,
    output slave_dbg_t            dbg_o
);

    localparam int OFF    = $clog2(STRB_WIDTH);
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);

    slave_state_e          state_q, state_d;
    logic [3:0]            lat_q;
    logic [7:0]            beat_q, len_q;
    logic [3:0]            id_q;
    logic [ADDR_WIDTH-1:0] idx_q, idx_nxt, mem_idx;
    logic [1:0]            burst_q;
    logic [2:0]            size_q;
    logic                  werr_q;
    logic                  beat_err, last_beat;
    logic                  mem_en, mem_we;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  aw_hs, ar_hs, r_hs, w_hs;

    // A transfer happens on a rising edge where valid and ready are both 1; a
    // valid, once raised, is held with its payload stable until that edge.
    assign aw_hs = awvalid_i && awready_o;
    assign ar_hs = arvalid_i && arready_o;
    assign r_hs  = rvalid_o && rready_i;
    assign w_hs  = wvalid_i && wready_o;

    assign idx_nxt   = (burst_q == BURST_FIXED) ? idx_q : idx_q + ADDR_WIDTH'(1);
    assign beat_err  = (idx_q >= DEPTH_W) || !burst_ok(burst_q);
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        arready_o = 1'b0;
        awready_o = 1'b0;
        rvalid_o  = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = idx_q;
        case (state_q)
            IDLE: begin
                awready_o = 1'b1;
                arready_o = !awvalid_i;
                if (awvalid_i)      state_d = WR_DATA;
                else if (arvalid_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                mem_en = !beat_err;
                if (lat_q == 4'd0) state_d = RD_DATA;
            end
            RD_DATA: begin
                rvalid_o = 1'b1;
                // Fetch the next word on the accepting edge so beats flow back to back.
                if (rready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        mem_idx = idx_nxt;
                        mem_en  = (idx_nxt < DEPTH_W) && burst_ok(burst_q);
                    end
                end
            end
            WR_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    mem_en = !beat_err;
                    mem_we = 1'b1;
                    if (wlast_i) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            idx_q   <= '0;
            burst_q <= '0;
            size_q  <= '0;
            werr_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                id_q    <= awid_i;
                idx_q   <= awaddr_i >> OFF;
                len_q   <= awlen_i;
                burst_q <= awburst_i;
                size_q  <= awsize_i;
                beat_q  <= '0;
                werr_q  <= 1'b0;
            end else if (ar_hs) begin
                id_q    <= arid_i;
                idx_q   <= araddr_i >> OFF;
                len_q   <= arlen_i;
                burst_q <= arburst_i;
                size_q  <= arsize_i;
                beat_q  <= '0;
                lat_q   <= 4'(RD_LATENCY - 1);
            end
            if (state_q == RD_WAIT && lat_q != 4'd0) lat_q <= lat_q - 4'd1;
            if (r_hs && !last_beat) begin
                beat_q <= beat_q + 8'd1;
                idx_q  <= idx_nxt;
            end
            // A beat count disagreeing with the burst length in either direction is an error.
            if (w_hs) begin
                if (beat_err || (wlast_i != last_beat)) werr_q <= 1'b1;
                beat_q <= beat_q + 8'd1;
                idx_q  <= idx_nxt;
            end
        end
    end

    sram_1rw #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .AW         (MEM_AW)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_idx[MEM_AW-1:0]),
        .wdata_i (wdata_i),
        .wstrb_i (wstrb_i),
        .rdata_o (mem_q)
    );

    assign rdata_o = (rvalid_o && !beat_err) ? mem_q : '0;
    assign rresp_o = (rvalid_o && beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign rlast_o = rvalid_o && last_beat;
    assign rid_o   = id_q;
    assign bid_o   = id_q;
    assign bresp_o = (bvalid_o && werr_q) ? RESP_SLVERR : RESP_OKAY;
    assign dbg_o   = '{state: state_q, size: size_q, beat: beat_q};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          arvalid_i = 0, arready_o;
    logic [3:0]    arid_i = 0;
    logic [AW-1:0] araddr_i = 0;
    logic [7:0]    arlen_i = 0;
    logic [2:0]    arsize_i = 3'd3;
    logic [1:0]    arburst_i = 0;
    logic          rvalid_o, rready_i = 0;
    logic [3:0]    rid_o;
    logic [DW-1:0] rdata_o;
    logic [1:0]    rresp_o;
    logic          rlast_o;
    logic          awvalid_i = 0, awready_o;
    logic [3:0]    awid_i = 0;
    logic [AW-1:0] awaddr_i = 0;
    logic [7:0]    awlen_i = 0;
    logic [2:0]    awsize_i = 3'd3;
    logic [1:0]    awburst_i = 0;
    logic          wvalid_i = 0, wready_o;
    logic [DW-1:0] wdata_i = 0;
    logic [SW-1:0] wstrb_i = 0;
    logic          wlast_i = 0;
    logic          bvalid_o, bready_i = 0;
    logic [3:0]    bid_o;
    logic [1:0]    bresp_o;
    slave_dbg_t    dbg;

    axi_sram_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .arid_i(arid_i), .araddr_i(araddr_i),
        .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o), .rdata_o(rdata_o),
        .rresp_o(rresp_o), .rlast_o(rlast_o),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awid_i(awid_i), .awaddr_i(awaddr_i),
        .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .wlast_i(wlast_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bid_o(bid_o), .bresp_o(bresp_o),
        .dbg_o(dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    logic [1:0]    exp_resp_q[$];
    logic [DW-1:0] wbeat_data [256];
    logic [SW-1:0] wbeat_strb [256];
    logic [5:0]    rr_pat = 6'b101101;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit beat_bad(input int idx, input logic [1:0] burst);
        return (idx >= DEPTH) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

    function automatic int beat_idx(input int start, input int b, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? start : start + b;
    endfunction

    // ---------------- driver tasks (all activity at posedge + 1) ----------------
    task automatic aw_send(input logic [3:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        awvalid_i = 1; awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst;
        #1;
        while (!awready_o && t < 100) begin @(posedge clk_i); #1; t++; end
        check("aw_ready", awready_o, 1);
        @(posedge clk_i); #1;
        awvalid_i = 0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        arvalid_i = 1; arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst;
        #1;
        while (!arready_o && t < 100) begin @(posedge clk_i); #1; t++; end
        check("ar_ready", arready_o, 1);
        @(posedge clk_i); #1;
        arvalid_i = 0;
    endtask

    task automatic w_send(input int word, input logic [7:0] len, input logic [1:0] burst,
                          input int last_at, output logic err);
        int idx;
        err = (last_at != int'(len));
        for (int b = 0; b <= last_at; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid_i = 0; @(posedge clk_i); #1;
            end
            wvalid_i = 1; wdata_i = wbeat_data[b]; wstrb_i = wbeat_strb[b];
            wlast_i = (b == last_at);
            #1;
            check("w_ready", wready_o, 1);
            @(posedge clk_i); #1;
            idx = beat_idx(word, b, burst);
            if (beat_bad(idx, burst)) err = 1;
            else for (int by = 0; by < SW; by++)
                if (wbeat_strb[b][by]) model_mem[idx][by*8 +: 8] = wbeat_data[b][by*8 +: 8];
        end
        wvalid_i = 0; wlast_i = 0;
    endtask

    task automatic b_recv(input logic [3:0] id, input logic err);
        int delay = $urandom_range(0, 2);
        logic [1:0] exp_resp = err ? RESP_SLVERR : RESP_OKAY;
        check("b_valid", bvalid_o, 1);
        bready_i = 0;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk_i); #1;
            check("b_hold_valid", bvalid_o, 1);
            check("b_hold_resp", bresp_o, exp_resp);
        end
        bready_i = 1;
        check("b_resp", bresp_o, exp_resp);
        check("b_id", bid_o, id);
        @(posedge clk_i); #1;
        bready_i = 0;
    endtask

    task automatic do_write(input logic [3:0] id, input int word, input logic [2:0] lowb,
                            input logic [7:0] len, input logic [1:0] burst, input int last_at);
        logic err;
        aw_send(id, AW'(word * 8) + AW'(lowb), len, burst);
        w_send(word, len, burst, last_at, err);
        b_recv(id, err);
    endtask

    // Collects the R beats of an accepted AR; abort_at >= 0 pulses reset on that beat.
    task automatic r_collect(input logic [3:0] id, input int word, input logic [7:0] len,
                             input logic [1:0] burst, input logic use_pat, input int abort_at);
        int lat = 0, beat = 0, cyc = 0, idx;
        exp_q.delete(); exp_resp_q.delete();
        for (int b = 0; b <= int'(len); b++) begin
            idx = beat_idx(word, b, burst);
            if (beat_bad(idx, burst)) begin exp_q.push_back('0); exp_resp_q.push_back(RESP_SLVERR); end
            else begin exp_q.push_back(model_mem[idx]); exp_resp_q.push_back(RESP_OKAY); end
        end
        do begin @(posedge clk_i); #1; lat++; end while (!rvalid_o && lat < 100);
        check("r_latency", lat, LAT);
        while (beat <= int'(len) && cyc < 2000) begin
            rready_i = use_pat ? ((cyc < 6) ? rr_pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
            #1;
            if (beat == abort_at) begin
                rst_ni = 0; #1;
                check("rst_rvalid", rvalid_o, 0);
                check("rst_rlast", rlast_o, 0);
                check("rst_rdata", rdata_o, 0);
                rready_i = 0;
                @(posedge clk_i); #1;
                rst_ni = 1;
                return;
            end
            check("r_valid", rvalid_o, 1);
            if (!rvalid_o) break;
            check("r_data", rdata_o, exp_q[0]);
            check("r_resp", rresp_o, exp_resp_q[0]);
            check("r_last", rlast_o, beat == int'(len));
            check("r_id", rid_o, id);
            if (rready_i) begin
                void'(exp_q.pop_front()); void'(exp_resp_q.pop_front());
                beat++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        rready_i = 0;
        check("r_back_idle", arready_o, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input int word, input logic [2:0] lowb,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic use_pat, input int abort_at);
        ar_send(id, AW'(word * 8) + AW'(lowb), len, burst);
        r_collect(id, word, len, burst, use_pat, abort_at);
    endtask

    task automatic fill_beats(input int n, input logic full);
        for (int b = 0; b < n; b++) begin
            wbeat_data[b] = {$urandom, $urandom};
            wbeat_strb[b] = full ? '1 : SW'($urandom_range(0, 255));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic err;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rvalid", rvalid_o, 0);
        check("rst_bvalid", bvalid_o, 0);
        check("rst_wready", wready_o, 0);
        check("rst_rlast", rlast_o, 0);
        check("rst_rresp", rresp_o, 0);
        check("rst_bresp", bresp_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_rid", rid_o, 0);
        check("rst_bid", bid_o, 0);
        rst_ni = 1;
        wvalid_i = 1; #1;
        check("w_before_aw", wready_o, 0);
        wvalid_i = 0;

        // Preload the regions the random phase touches.
        fill_beats(64, 1); do_write(4'h1, 0, 0, 8'd63, BURST_INCR, 63);
        fill_beats(8, 1);  do_write(4'h2, 1016, 0, 8'd7, BURST_INCR, 7);

        // Single-beat write then read at 0x10.
        wbeat_data[0] = 64'hDEAD_BEEF_CAFE_F00D; wbeat_strb[0] = '1;
        do_write(4'h3, 2, 0, 8'd0, BURST_INCR, 0);
        do_read(4'h5, 2, 0, 8'd0, BURST_INCR, 0, -1);

        // INCR burst of 4 from word 2 under a stalling rready pattern.
        do_read(4'h6, 2, 0, 8'd3, BURST_INCR, 1, -1);

        // Strobed write over all-ones.
        wbeat_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbeat_strb[0] = '1;
        do_write(4'h7, 8, 0, 8'd0, BURST_INCR, 0);
        wbeat_data[0] = 64'h1111_2222_3333_4444; wbeat_strb[0] = 8'h0F;
        do_write(4'h7, 8, 0, 8'd0, BURST_INCR, 0);
        do_read(4'h8, 8, 0, 8'd0, BURST_INCR, 0, -1);

        // Simultaneous AR and AW: write goes first, read waits for B.
        fill_beats(2, 1);
        awvalid_i = 1; awid_i = 4'h9; awaddr_i = 32'h60; awlen_i = 8'd1; awburst_i = BURST_INCR;
        arvalid_i = 1; arid_i = 4'hA; araddr_i = 32'h60; arlen_i = 8'd1; arburst_i = BURST_INCR;
        #1;
        check("arb_awready", awready_o, 1);
        check("arb_arready", arready_o, 0);
        @(posedge clk_i); #1;
        awvalid_i = 0; #1;
        check("arb_ar_blocked", arready_o, 0);
        w_send(12, 8'd1, BURST_INCR, 1, err);
        check("arb_ar_blocked_b", arready_o, 0);
        b_recv(4'h9, err);
        check("arb_ar_after_b", arready_o, 1);
        @(posedge clk_i); #1;
        arvalid_i = 0;
        r_collect(4'hA, 12, 8'd1, BURST_INCR, 0, -1);

        // Out-of-range read and short write burst.
        do_read(4'hB, DEPTH, 0, 8'd0, BURST_INCR, 0, -1);
        fill_beats(2, 1);
        do_write(4'hC, 30, 0, 8'd1, BURST_INCR, 0);
        do_read(4'hD, 1022, 0, 8'd3, BURST_INCR, 0, -1);

        // Reset on beat 2 of 4, then a normal read.
        do_read(4'hE, 20, 0, 8'd3, BURST_INCR, 0, 2);
        do_read(4'hF, 20, 0, 8'd3, BURST_INCR, 0, -1);

        // Random mix of reads and writes.
        for (int n = 0; n < 60; n++) begin
            int word, last_at, r;
            logic [7:0] len;
            logic [1:0] burst;
            word = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 56) : $urandom_range(1016, 1030);
            len = 8'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            burst = (r < 5) ? BURST_INCR : (r < 8) ? BURST_FIXED : (r == 8) ? BURST_WRAP : 2'b11;
            if ($urandom_range(0, 1) == 1) begin
                fill_beats(int'(len) + 1, $urandom_range(0, 1) == 1);
                last_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : int'(len);
                do_write(4'($urandom_range(0, 15)), word, 3'($urandom_range(0, 7)), len, burst, last_at);
            end else begin
                do_read(4'($urandom_range(0, 15)), word, 3'($urandom_range(0, 7)), len, burst, 0, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 64, sets the data-bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, sets the address width in bits.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, sets the write-strobe width.
REQ-004 Parameter MEM_DEPTH, default 1024, is the number of DATA_WIDTH-bit words in storage.
REQ-005 Parameter RD_LATENCY, default 1, range 1..15, is the number of cycles from AR handshake to first rvalid.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, with the following ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- AR channel (master to slave): arvalid_i 1, arready_o 1 (out), arid_i 4, araddr_i ADDR_WIDTH, arlen_i 8, arsize_i 3, arburst_i 2.
- R channel (slave to master): rvalid_o 1, rready_i 1 (in), rid_o 4, rdata_o DATA_WIDTH, rresp_o 2, rlast_o 1.
- AW channel (master to slave): awvalid_i 1, awready_o 1 (out), awid_i 4, awaddr_i ADDR_WIDTH, awlen_i 8, awsize_i 3, awburst_i 2.
- W channel (master to slave): wvalid_i 1, wready_o 1 (out), wdata_i DATA_WIDTH, wstrb_i STRB_WIDTH, wlast_i 1.
- B channel (slave to master): bvalid_o 1, bready_i 1 (in), bid_o 4, bresp_o 2.

Function
REQ-007 The FSM SHALL have states IDLE, RD_WAIT, RD_DATA, WR_DATA and WR_RESP, and SHALL run one transaction at a time.
REQ-008 In IDLE, awready_o SHALL be 1; arready_o SHALL be 1 only when awvalid_i is 0 (writes win simultaneous requests); both SHALL be 0 in every other state.
REQ-009 On an AR handshake, the block SHALL latch arid, araddr, arlen and arburst, load the latency counter with RD_LATENCY-1, and go to RD_WAIT.
REQ-010 RD_WAIT SHALL count down to 0 and then enter RD_DATA with rvalid_o=1, so the first beat appears exactly RD_LATENCY cycles after the AR handshake.
REQ-011 In RD_DATA, each rvalid_o&&rready_i beat SHALL advance the beat counter and present the next beat on the following cycle, with no bubble.
REQ-012 While rvalid_o=1 and rready_i=0, rdata_o, rresp_o, rlast_o and rid_o SHALL be held stable.
REQ-013 rlast_o SHALL be 1 only on beat arlen; its handshake SHALL return the FSM to IDLE.
REQ-014 The word index SHALL be addr >> log2(STRB_WIDTH); INCR bursts SHALL add 1 per beat and FIXED bursts SHALL keep the index constant.
REQ-015 Any beat whose index is >= MEM_DEPTH, or any beat of a burst with burst type WRAP or reserved (2'b11), SHALL return resp 2'b10 (SLVERR) with data 0, and SHALL leave storage untouched; all other beats SHALL return 2'b00 (OKAY).
REQ-016 On an AW handshake, the block SHALL latch awid, awaddr, awlen and awburst and go to WR_DATA; wready_o SHALL be 1 throughout WR_DATA.
REQ-017 Each W handshake SHALL write only the bytes whose wstrb_i bit is 1, at the current index, and SHALL then advance the index per REQ-014.
REQ-018 The W handshake with wlast_i=1 SHALL move the FSM to WR_RESP, with bvalid_o=1 on the next cycle and bid_o equal to the latched awid.
REQ-019 bresp_o SHALL be SLVERR if any beat of the write was in error, or if wlast_i arrived on a beat other than beat awlen; otherwise it SHALL be OKAY.
REQ-020 bvalid_o and bresp_o SHALL be held until bready_i is 1; the B handshake SHALL return the FSM to IDLE.
REQ-021 A W beat presented before its AW handshake SHALL NOT be accepted (wready_o=0 outside WR_DATA).
REQ-022 arsize and awsize SHALL be latched but SHALL NOT change addressing (full-width beats only).

Reset
REQ-023 While rst_ni=0, the FSM SHALL be IDLE, all counters 0, and rvalid_o, bvalid_o, wready_o, rlast_o=0, rresp_o, bresp_o=2'b00, rdata_o=0, rid_o, bid_o=0.
REQ-024 Reset asserted mid-burst SHALL abandon the transaction without issuing a response; storage contents need not be cleared.
REQ-025 The first handshake SHALL be possible on the first clock edge after rst_ni deasserts.

Structure
REQ-026 Package axi_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants, the BURST_FIXED/INCR/WRAP constants and the slave state enum.
REQ-027 Storage SHALL be a sub-module sram_1rw: single port, synchronous read, byte-enable write, depth MEM_DEPTH.

Verification
REQ-028 Single read: AR with addr 0x10 and len 0 after a write of 0xDEADBEEF_CAFEF00D to 0x10 -> rvalid exactly RD_LATENCY cycles later with that data, rlast=1, rresp=00, rid=arid.
REQ-029 INCR read burst: len 3 with rready toggling 1,0,1,1,0,1 -> 4 beats of words 2..5 in order, rdata stable during stalls, rlast only on the 4th beat.
REQ-030 Strobed write: wstrb 0x0F with data 0x1111_2222_3333_4444 over existing 0xFFFF_FFFF_FFFF_FFFF -> readback 0xFFFF_FFFF_3333_4444, bresp=00.
REQ-031 Simultaneous arvalid and awvalid in IDLE -> AW accepted first; AR accepted only after the B handshake.
REQ-032 Out-of-range: araddr = MEM_DEPTH*8 -> rresp=10 and rdata=0; a write burst with len 1 but wlast on beat 0 -> bresp=10.
REQ-033 Reset pulse during RD_DATA beat 2 of 4 -> rvalid_o=0 immediately; the next AR completes normally.
